mips_multicycle_control: RTL

- Main control FSM that sequences the MIPS datapath over multiple cycles per instruction: fetch, decode, execute, memory and writeback.
- Decodes the opcode and drives the datapath selects and write enables.
- Supplies the 2-bit ula_operation consumed by ula_control.
- Inserts wait states on memory accesses via a ready handshake.

---
 rtl/mips_multicycle_control.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_control.sv
// Main control FSM for a multicycle MIPS datapath.
// It steps each instruction through fetch, decode, execute, memory and
// writeback, and drives the datapath selects and write enables.
// Memory accesses hold their state until mem_ready comes back.
// Optional feature: define MIPS_CTRL_BNE_EN to add branch-not-equal support.
// That adds the branch_ne output and the BRANCHNE state (13).
//
// Handshake: a memory request (mem_read / mem_write) is held stable while the
// FSM waits. The access completes in the first cycle where mem_ready=1, and
// the FSM moves on at the following clock edge. A FETCH completes on the same
// mem_ready cycle, so ir_write and pc_write are only asserted in that cycle.
module mips_multicycle_control (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
`ifdef MIPS_CTRL_BNE_EN
  output logic       branch_ne,
`endif
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ula_operation,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
`ifdef MIPS_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'h05;
`endif

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_EXEC     = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11,
`ifdef MIPS_CTRL_BNE_EN
    S_JUMP     = 4'd12,
    S_BRANCHNE = 4'd13
`else
    S_JUMP     = 4'd12
`endif
  } state_t;

  state_t cur_state;
  state_t nxt_state;

  assign state = cur_state;

  // State register. Asynchronous reset forces RST, which decodes to all-zero
  // outputs, so no write enable survives past the reset edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_state <= S_RST;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state and output decode. The outputs are Moore outputs, except that
  // FETCH gates its PC and IR writes with mem_ready.
  always_comb begin
    nxt_state     = cur_state;
    pc_write      = 1'b0;
    branch        = 1'b0;
`ifdef MIPS_CTRL_BNE_EN
    branch_ne     = 1'b0;
`endif
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ula_operation = 2'b00;
    pc_src        = 2'b00;
    illegal_op    = 1'b0;

    case (cur_state)
      S_RST: begin
        nxt_state = S_FETCH;
      end

      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;           // PC + 4
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          nxt_state = S_DECODE;
        end
      end

      S_DECODE: begin
        alu_src_b = 2'b11;           // precompute the branch target
        case (opcode)
          OP_LW, OP_SW: nxt_state = S_MEMADR;
          OP_RTYPE:     nxt_state = S_EXEC;
          OP_BEQ:       nxt_state = S_BRANCH;
          OP_J:         nxt_state = S_JUMP;
          OP_ADDI:      nxt_state = S_ADDIEX;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       nxt_state = S_BRANCHNE;
`endif
          default: begin
            illegal_op = 1'b1;
            nxt_state  = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // Opcode is looked at again here. If it is no longer a memory op,
        // the instruction is abandoned and a new fetch starts.
        if (opcode == OP_LW) begin
          nxt_state = S_MEMRD;
        end else if (opcode == OP_SW) begin
          nxt_state = S_MEMWR;
        end else begin
          nxt_state = S_FETCH;
        end
      end

      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          nxt_state = S_MEMWB;
        end
      end

      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        nxt_state  = S_FETCH;
      end

      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          nxt_state = S_FETCH;
        end
      end

      S_EXEC: begin
        alu_src_a     = 1'b1;
        ula_operation = 2'b10;
        nxt_state     = S_ALUWB;
      end

      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        nxt_state = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        ula_operation = 2'b01;
        branch        = 1'b1;
        pc_src        = 2'b01;
        nxt_state     = S_FETCH;
      end

      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt_state = S_ADDIWB;
      end

      S_ADDIWB: begin
        reg_write = 1'b1;
        nxt_state = S_FETCH;
      end

      S_JUMP: begin
        pc_write  = 1'b1;
        pc_src    = 2'b10;
        nxt_state = S_FETCH;
      end

`ifdef MIPS_CTRL_BNE_EN
      S_BRANCHNE: begin
        alu_src_a     = 1'b1;
        ula_operation = 2'b01;
        branch_ne     = 1'b1;
        pc_src        = 2'b01;
        nxt_state     = S_FETCH;
      end
`endif

      // Unused encodings keep every output at 0 and recover through FETCH.
      default: begin
        nxt_state = S_FETCH;
      end
    endcase
  end

endmodule
